ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, with fast-path results for divide-by-zero and signed overflow.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [2:0]          op_q, op_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                done_q, done_d;

    logic                is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum, div_trial, div_diff;
    logic                q_bit;
    logic [XLEN-1:0]     new_rem;
    logic [2*XLEN-1:0]   step, prod_fin;
    logic [XLEN-1:0]     quo_fin, rem_fin, final_res;

    always_comb begin
        is_div   = funct3[2];
        a_sgn    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        b_sgn    = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        a_neg    = a_sgn && a[XLEN-1];
        b_neg    = b_sgn && b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = is_div && (b == '0);
        div_ovf  = is_div && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    end

    // One iteration: multiply adds the multiplicand when the low multiplier bit is set and
    // shifts right; divide shifts the next dividend bit into the partial remainder.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, opnd_q};
        q_bit     = div_trial >= {1'b0, opnd_q};
        new_rem   = q_bit ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
        step      = op_q[2] ? {new_rem, acc_q[XLEN-2:0], q_bit}
                            : {mul_sum, acc_q[XLEN-1:1]};
        prod_fin  = neg_res_q ? -step : step;
        quo_fin   = neg_res_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem_fin   = neg_rem_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:       final_res = prod_fin[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       final_res = prod_fin[2*XLEN-1:XLEN];
            3'd4, 3'd5: final_res = quo_fin;
            default:    final_res = rem_fin;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        result_d  = result_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_d      = funct3;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = '0;
                        if (div_zero) begin
                            result_d = funct3[1] ? a : '1;
                            done_d   = 1'b1;
                            state_d  = DONE;
                        end else if (div_ovf) begin
                            result_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                            done_d   = 1'b1;
                            state_d  = DONE;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                            opnd_d  = is_div ? b_mag : a_mag;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        result_d = final_res;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
        end
    end

    assign stall  = !flush && (((state_q == IDLE) && start) || (state_q == CALC));
    assign done   = done_q && !flush;
    assign result = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written flush and mid-operation reset sequences.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall, done;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .a(a), .b(b),
        .flush(flush), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        case (f)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                return $signed(x) / $signed(y);
            end
            3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
        return 33;
    endfunction

    // Issue one op at a falling edge, count stall cycles and edges until done.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int stalls;
        logic [31:0] got;
        @(negedge clk);
        funct3 = f; a = x; b = y; start = 1'b1;
        #1;
        stalls = stall ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (stall) stalls++;
            @(negedge clk);
            lat++;
        end
        got = result;
        $display("%s f=%0d a=%08h b=%08h -> %08h lat=%0d stall_cycles=%0d",
                 name, f, x, y, got, lat, stalls);
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, got, exp_res);
        check({name, " stall cycles"}, stalls, exp_lat);
        check({name, " stall in done"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        check({name, " done pulse width"}, {31'd0, done}, 32'd0);
        check({name, " result hold"}, result, exp_res);
    endtask

    initial begin
        int dcount;
        int scount;
        logic [2:0]  rf;
        logic [31:0] rx, ry;

        tbl.push_back('{"MUL 7*-3",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
        tbl.push_back('{"MULH min*min",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33});
        tbl.push_back('{"MULHU max*max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        tbl.push_back('{"MULHSU -1*2",   3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
        tbl.push_back('{"DIV -7/2",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        tbl.push_back('{"REM -7%2",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        tbl.push_back('{"DIVU 100/7",    3'd5, 32'd100,      32'd7,        32'd14,       33});
        tbl.push_back('{"REMU 100%7",    3'd7, 32'd100,      32'd7,        32'd2,        33});
        tbl.push_back('{"DIVU 5/0",      3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        tbl.push_back('{"REM 5/0",       3'd6, 32'd5,        32'd0,        32'd5,        1});
        tbl.push_back('{"DIV ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        tbl.push_back('{"REM ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
        tbl.push_back('{"DIVU ovf-like", 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33});

        #12;
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_op(tbl[i].name, tbl[i].f, tbl[i].x, tbl[i].y, tbl[i].res, tbl[i].lat);

        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       rx = 32'($urandom_range(0, 300));
                1:       rx = 32'h80000000;
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1:       ry = 32'hFFFFFFFF;
                2:       ry = 32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            run_op("RAND", rf, rx, ry, ref_model(rf, rx, ry), ref_lat(rf, rx, ry));
        end

        // Flush at CALC iteration 10.
        @(negedge clk);
        funct3 = 3'd0; a = 32'd123; b = 32'd456; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush stall comb", {31'd0, stall}, 32'd0);
        check("flush done comb", {31'd0, done}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush stall next", {31'd0, stall}, 32'd0);
        dcount = 0;
        scount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
            if (stall) scount++;
        end
        $display("flush: done pulses=%0d stall cycles=%0d", dcount, scount);
        check("flush no done", dcount, 32'd0);
        check("flush no stall", scount, 32'd0);
        run_op("MULHU 3*3 after flush", 3'd3, 32'd3, 32'd3, 32'd0, 33);

        // Reset at CALC iteration 20.
        run_op("DIVU pre-reset", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        @(negedge clk);
        funct3 = 3'd0; a = 32'd7; b = 32'hFFFFFFFD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst stall", {31'd0, stall}, 32'd0);
        dcount = 0;
        scount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
            if (stall) scount++;
        end
        $display("reset: done pulses=%0d stall cycles=%0d result=%08h", dcount, scount, result);
        check("post-rst no done", dcount, 32'd0);
        check("post-rst no stall", scount, 32'd0);
        check("post-rst result", result, 32'd0);
        run_op("DIVU fresh", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
